// File: rtl/axi_b_resp_gen.sv
// axi_b_resp_gen: pairs AW commands with W burst completions in order and issues registered B responses.
// Error reporting (SLVERR on any errored beat) is compiled only with AXI_B_RESP_GEN_ERR_EN defined.
module axi_b_resp_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 6,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [USER_WIDTH-1:0] aw_user_i,
  output logic                  aw_ready_o,
  input  logic                  w_valid_i,
  input  logic                  w_last_i,
  input  logic                  w_err_i,
  output logic                  w_ready_o,
  output logic                  b_valid_o,
  output logic [1:0]            b_resp_o,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [USER_WIDTH-1:0] b_user_o,
  input  logic                  b_ready_i
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int AWW = ID_WIDTH + USER_WIDTH;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [AWW-1:0] aw_mem [DEPTH];
  logic [1:0]     cmp_mem [DEPTH];
  logic [PW-1:0]  aw_wp, aw_rp, cmp_wp, cmp_rp;
  logic [CW-1:0]  aw_cnt, cmp_cnt;
  logic           aw_push, w_acc, cmp_push, pop;
  logic [1:0]     cmp_resp;
  assign aw_ready_o = (aw_cnt != CW'(DEPTH)) && !rst_i;
  assign w_ready_o  = (cmp_cnt != CW'(DEPTH)) && !rst_i;
  assign aw_push    = aw_valid_i && aw_ready_o;
  assign w_acc      = w_valid_i && w_ready_o;
  assign cmp_push   = w_acc && w_last_i;
  assign pop        = (aw_cnt != '0) && (cmp_cnt != '0) && (state == EMPTY || b_ready_i);
`ifdef AXI_B_RESP_GEN_ERR_EN
  logic err_acc;
  assign cmp_resp = (err_acc || w_err_i) ? 2'b10 : 2'b00;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_acc <= 1'b0;
    else if (w_acc) err_acc <= w_last_i ? 1'b0 : (err_acc || w_err_i);
  end
`else
  logic unused_err;
  assign unused_err = w_err_i;
  assign cmp_resp   = 2'b00;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_wp   <= '0;
      aw_rp   <= '0;
      aw_cnt  <= '0;
      cmp_wp  <= '0;
      cmp_rp  <= '0;
      cmp_cnt <= '0;
    end else begin
      if (aw_push) begin
        aw_mem[aw_wp] <= {aw_id_i, aw_user_i};
        aw_wp         <= aw_wp + 1'b1;
      end
      if (cmp_push) begin
        cmp_mem[cmp_wp] <= cmp_resp;
        cmp_wp          <= cmp_wp + 1'b1;
      end
      if (pop) begin
        aw_rp  <= aw_rp + 1'b1;
        cmp_rp <= cmp_rp + 1'b1;
      end
      aw_cnt  <= aw_cnt + CW'(aw_push) - CW'(pop);
      cmp_cnt <= cmp_cnt + CW'(cmp_push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else state <= state_nxt;
  end
  always_comb state_nxt = pop ? FULL : (b_ready_i ? EMPTY : state);
  always_comb b_valid_o = (state == FULL);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_resp_o <= '0;
      b_id_o   <= '0;
      b_user_o <= '0;
    end else if (pop) begin
      b_resp_o           <= cmp_mem[cmp_rp];
      {b_id_o, b_user_o} <= aw_mem[aw_rp];
    end
  end
endmodule
